// File: rtl/wr_fifo_ctrl.sv
// Write-side controller of an async FIFO: pointers, full/level flags,
// sticky overflow. rd_ptr_gray arrives already synchronised into clk.
module wr_fifo_ctrl #(
  parameter int    ADDR_WDTH    = 4,
  parameter string SYNC_FULL_N  = "TRUE",
  parameter int    AFULL_THRESH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_WDTH-1:0] rd_ptr_gray,
  output logic [ADDR_WDTH-1:0] wr_ptr_gray,
  output logic [ADDR_WDTH-1:0] wr_ptr_bin,
  output logic                 full_n,
  output logic [ADDR_WDTH-1:0] wr_level,
  output logic                 almost_full,
  output logic                 overflow
);

  localparam bit SYNC = (SYNC_FULL_N == "TRUE");
  localparam logic [ADDR_WDTH-1:0] ONE = 1;
  localparam logic [ADDR_WDTH-1:0] THR = ADDR_WDTH'(AFULL_THRESH);

  logic [ADDR_WDTH-1:0] wr_ptr;
  logic [ADDR_WDTH-1:0] rd_ptr;
  logic [ADDR_WDTH-1:0] next_wr_ptr;
  logic                 full_w;
  logic                 full_r;
  logic                 accept;

  // Binary bit j is the XOR of all Gray bits from j up to the MSB
  always_comb begin
    rd_ptr = '0;
    for (int j = 0; j < ADDR_WDTH; j++) begin
      rd_ptr[j] = ^(rd_ptr_gray >> j);
    end
  end

  always_comb begin
    full_w      = ((wr_ptr + ONE) == rd_ptr);
    accept      = wr_en & ~full_w & ~(SYNC & full_r);
    next_wr_ptr = accept ? (wr_ptr + ONE) : wr_ptr;
    wr_level    = wr_ptr - rd_ptr;
  end

  assign full_n     = accept;
  assign wr_ptr_bin = wr_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      wr_ptr_gray <= '0;
      full_r      <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_ptr      <= next_wr_ptr;
      wr_ptr_gray <= next_wr_ptr ^ (next_wr_ptr >> 1);
      full_r      <= full_w;
      almost_full <= (wr_level >= THR);
      overflow    <= overflow | (wr_en & ~accept);
    end
  end

endmodule

// File: tb/tb_wr_fifo_ctrl.sv
// Bench for wr_fifo_ctrl: conservative (inst 0) and fast-full (inst 1)
// variants side by side, checked against an occupancy-based model.
module tb_wr_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] rd_ptr_gray;

  logic [3:0] wr_gray  [2];
  logic [3:0] wr_bin   [2];
  logic       full_n   [2];
  logic [3:0] wr_level [2];
  logic       afull    [2];
  logic       ovf      [2];

  int total = 0;
  int pass  = 0;

  logic       i_we;
  logic       i_rst;
  logic [3:0] m_rd;
  logic [3:0] m_wr    [2];
  logic       m_fullr [2];
  logic       m_af    [2];
  logic       m_ovf   [2];

  always #5 clk = ~clk;

  wr_fifo_ctrl #(
    .ADDR_WDTH(4), .SYNC_FULL_N("TRUE"), .AFULL_THRESH(12)
  ) dut_t (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en),
    .rd_ptr_gray(rd_ptr_gray),
    .wr_ptr_gray(wr_gray[0]), .wr_ptr_bin(wr_bin[0]),
    .full_n(full_n[0]), .wr_level(wr_level[0]),
    .almost_full(afull[0]), .overflow(ovf[0])
  );

  wr_fifo_ctrl #(
    .ADDR_WDTH(4), .SYNC_FULL_N("FALSE"), .AFULL_THRESH(12)
  ) dut_f (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en),
    .rd_ptr_gray(rd_ptr_gray),
    .wr_ptr_gray(wr_gray[1]), .wr_ptr_bin(wr_bin[1]),
    .full_n(full_n[1]), .wr_level(wr_level[1]),
    .almost_full(afull[1]), .overflow(ovf[1])
  );

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Occupancy seen from the write side; 15 entries means full
  function automatic logic [3:0] lvl(input int k);
    return m_wr[k] - m_rd;
  endfunction

  function automatic logic acc(input int k);
    return i_we && (lvl(k) != 4'd15) && !(k == 0 && m_fullr[k]);
  endfunction

  function automatic logic [14:0] obs(input int k);
    return {full_n[k], wr_level[k], wr_bin[k], wr_gray[k],
            afull[k], ovf[k]};
  endfunction

  function automatic logic [14:0] expv(input int k);
    return {acc(k), lvl(k), m_wr[k], to_gray(m_wr[k]),
            m_af[k], m_ovf[k]};
  endfunction

  task automatic drive(input logic we, input logic [3:0] rd,
                       input logic rst);
    i_we        = we;
    i_rst       = rst;
    m_rd        = rd;
    wr_en       = we;
    rst_n       = rst;
    rd_ptr_gray = to_gray(rd);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!i_rst) begin
        m_wr[k]    = '0;
        m_fullr[k] = 1'b0;
        m_af[k]    = 1'b0;
        m_ovf[k]   = 1'b0;
      end else begin
        logic a;
        a          = acc(k);
        m_fullr[k] = (lvl(k) == 4'd15);
        m_af[k]    = (lvl(k) >= 4'd12);
        m_ovf[k]   = m_ovf[k] | (i_we & ~a);
        m_wr[k]    = m_wr[k] + {3'd0, a};
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0);
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs(k) !== expv(k))
        $display("FAIL reset_idle inst%0d got %h exp %h",
                 k, obs(k), expv(k));
      else pass++;
    end
    drive(1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (full_n[k] !== 1'b1 || obs(k) !== expv(k))
        $display("FAIL reset_we inst%0d got %h exp %h",
                 k, obs(k), expv(k));
      else pass++;
    end
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 1);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expv(k))
          $display("FAIL fill%0d inst%0d got %h exp %h",
                   i, k, obs(k), expv(k));
        else pass++;
      end
      tick();
    end
    drive(1, 0, 1);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (wr_level[k] !== 4'd15 || ovf[k] !== 1'b1 ||
          afull[k] !== 1'b1 || wr_bin[k] !== 4'd15)
        $display("FAIL fill_end inst%0d got %h exp lvl=f ovf=1 af=1",
                 k, obs(k));
      else pass++;
    end
  endtask

  task automatic test_release();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1);
      if (i == 0) begin
        total++;
        if (full_n[0] !== 1'b0 || full_n[1] !== 1'b1)
          $display("FAIL release_first got %b%b exp 01",
                   full_n[0], full_n[1]);
        else pass++;
      end
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expv(k))
          $display("FAIL release%0d inst%0d got %h exp %h",
                   i, k, obs(k), expv(k));
        else pass++;
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [3:0] prev;
    drive(0, 0, 0);
    tick();
    for (int i = 0; i < 40; i++) begin
      drive(1, m_wr[0] - 4'd1, 1);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expv(k))
          $display("FAIL wrap%0d inst%0d got %h exp %h",
                   i, k, obs(k), expv(k));
        else pass++;
      end
      prev = wr_gray[0];
      tick();
      total++;
      if ($countones(prev ^ wr_gray[0]) !== 1)
        $display("FAIL wrap_gray%0d got %b->%b exp one bit",
                 i, prev, wr_gray[0]);
      else pass++;
    end
  endtask

  task automatic test_midburst_reset();
    drive(0, 0, 0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 1);
      tick();
    end
    drive(1, 8, 1);
    tick();
    drive(0, 8, 1);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (wr_bin[k] !== 4'd7 || ovf[k] !== 1'b1)
        $display("FAIL pre_reset inst%0d got %h exp ptr=7 ovf=1",
                 k, obs(k));
      else pass++;
    end
    drive(1, 8, 0);
    tick();
    drive(0, 8, 1);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (wr_bin[k] !== 4'd0 || wr_gray[k] !== 4'd0 ||
          ovf[k] !== 1'b0 || afull[k] !== 1'b0)
        $display("FAIL post_reset inst%0d got %h exp zeros",
                 k, obs(k));
      else pass++;
    end
    tick();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 30; i++) begin
      drive(0, 4'($urandom_range(0, 15)), 1);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (full_n[k] !== 1'b0 || wr_bin[k] !== 4'd0 ||
            ovf[k] !== 1'b0 || obs(k) !== expv(k))
          $display("FAIL idle%0d inst%0d got %h exp %h",
                   i, k, obs(k), expv(k));
        else pass++;
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] rd;
      rd = ($urandom_range(0, 3) == 0) ?
           4'($urandom_range(0, 15)) : m_rd;
      drive(1'($urandom_range(0, 1)), rd,
            ($urandom_range(0, 60) != 0));
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expv(k))
          $display("FAIL random%0d inst%0d got %h exp %h",
                   i, k, obs(k), expv(k));
        else pass++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_release();
    test_wrap();
    test_midburst_reset();
    test_idle();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
